reg_ctx_swap_ctrl: RTL and testbench
====================================

// Module: reg_ctx_swap_ctrl
// PURPOSE
//  Context save/restore sequencer between the register file (RF) and the register memory (RM).
//  On SAVE_REQ it copies every RF register into one RM context slot; on RESTORE_REQ it copies the slot back.
//  It stalls the pipeline with BUSYWAIT for the whole transfer.
//  It is the only master of the RF side port and of the RM port during a transfer.
// PARAMETERS
//  NUM_REGS  32  registers per context
//  ADDR_W    5   RF index width, log2(NUM_REGS)
//  DATA_W    32  register width
//  SLOT_W    2   context slot select width (2**SLOT_W slots in RM)
//  SKIP_X0   1   1: index 0 (hard-wired zero) is never saved or restored
// PORTS
//  CLK           in   1               clock; all state changes on posedge
//  RESET         in   1               asynchronous, active-low reset
//  SAVE_REQ      in   1               level request: RF -> RM
//  RESTORE_REQ   in   1               level request: RM -> RF
//  SLOT          in   SLOT_W          context slot; sampled with the request
//  BUSYWAIT      out  1               stall to the pipeline
//  DONE          out  1               1-cycle pulse: transfer finished
//  RF_ADDR       out  ADDR_W          RF side-port index
//  RF_READDATA   in   DATA_W          RF combinational read data at RF_ADDR
//  RF_WRITEDATA  out  DATA_W          RF write data
//  RF_WRITE      out  1               RF write enable, 1 cycle per register
//  RM_ADDR       out  SLOT_W+ADDR_W   {slot, index}
//  RM_WRITEDATA  out  DATA_W          RM write data
//  RM_READDATA   in   DATA_W          RM read data; valid when RM_BUSYWAIT=0
//  RM_READ       out  1               RM read strobe, held until accepted
//  RM_WRITE      out  1               RM write strobe, held until accepted
//  RM_BUSYWAIT   in   1               RM stall; an access is accepted at the first posedge with strobe=1 and RM_BUSYWAIT=0
// BEHAVIOUR
//  Reset (RESET=0, async)
//   - state=IDLE; index and slot registers cleared.
//   - All outputs are 0, BUSYWAIT included.
//   - A partially written slot is left as-is; there is no rollback.
//  FSM states: IDLE, SV_RD, SV_WR, RS_RD, RS_WR, FIN.
//  IDLE
//   - At posedge: if SAVE_REQ=1, latch SLOT, set idx=(SKIP_X0?1:0), go to SV_RD.
//   - Else if RESTORE_REQ=1: same latch, go to RS_RD.
//   - SAVE wins when both are high.
//  SV_RD
//   - RF_ADDR=idx; capture RF_READDATA into the data register; go to SV_WR.
//  SV_WR
//   - RM_WRITE=1, RM_ADDR={slot,idx}, RM_WRITEDATA=data register.
//   - Stay while RM_BUSYWAIT=1.
//   - On accept: if idx==NUM_REGS-1 go to FIN; else idx++ and go to SV_RD.
//  RS_RD
//   - RM_READ=1, RM_ADDR={slot,idx}.
//   - Stay while RM_BUSYWAIT=1; on accept, capture RM_READDATA and go to RS_WR.
//  RS_WR
//   - RF_WRITE=1 for exactly 1 cycle; RF_ADDR=idx; RF_WRITEDATA=data register.
//   - Then go to FIN if idx==NUM_REGS-1; else idx++ and go to RS_RD.
//  FIN
//   - DONE=1 and BUSYWAIT=0 for 1 cycle; requests are ignored in this state.
//   - Next state IDLE.
//   - A requester must drop its request while DONE=1; a request still high in IDLE starts a new transfer.
//  BUSYWAIT
//   - Combinational: 1 when state is not IDLE or FIN, or when state is IDLE and SAVE_REQ|RESTORE_REQ.
//   - So the stall begins in the same cycle as the request.
//  Outputs
//   - Strobes, RF_ADDR and RM_ADDR are 0 outside their states; no glitching strobes.
//   - RM_READ and RM_WRITE are never both 1; RF_WRITE is never 1 during a save.
//  Latency
//   - Zero-wait RM, SKIP_X0=1: 2 cycles per register, 62 cycles from request sample to FIN; DONE in cycle 63.
//   - Each RM wait cycle adds 1 cycle.
//  Widths
//   - idx is ADDR_W bits; it never wraps past NUM_REGS-1 (terminal compare, not overflow).
//   - Changing SLOT mid-transfer has no effect.
// TESTING
//  T1 Save, zero-wait: RF[i]=0x1000+i, SLOT=2, SAVE_REQ
//     -> RM[{2,i}]=0x1000+i for i=1..31; no write to {2,0}; DONE exactly 63 cycles after request.
//  T2 Restore, RM_BUSYWAIT high 3 cycles per access: RM[{1,i}]=~i, SLOT=1
//     -> each RM_READ held 4 cycles; RF[i]=~i for i=1..31; RF_WRITE is 31 single-cycle pulses.
//  T3 SAVE_REQ=RESTORE_REQ=1 in the same cycle
//     -> save runs, RM_READ never asserted; BUSYWAIT=1 in the request cycle.
//  T4 RESET=0 asynchronously while SV_WR, idx=10
//     -> all outputs 0 immediately; after release, IDLE; the next save starts from idx=1.
//  T5 Back-to-back: request drops on DONE, then save slot 3 and restore slot 3
//     -> RF contents unchanged; exactly 2 DONE pulses; no transfer starts in FIN.
//  T6 SKIP_X0=0 with SLOT=0
//     -> RM[{0,0}] written with RF[0]; 64 cycles to FIN.

Source files
------------

// File: rtl/reg_ctx_swap_ctrl.sv
// reg_ctx_swap_ctrl: sequences a context save (RF -> RM slot) or restore (RM slot -> RF),
// one register at a time, stalling the pipeline for the whole transfer.
module reg_ctx_swap_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int SLOT_W   = 2,
    parameter bit SKIP_X0  = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     save_req_i,
    input  logic                     restore_req_i,
    input  logic [SLOT_W-1:0]        slot_i,
    output logic                     busywait_o,
    output logic                     done_o,
    output logic [ADDR_W-1:0]        rf_addr_o,
    input  logic [DATA_W-1:0]        rf_readdata_i,
    output logic [DATA_W-1:0]        rf_writedata_o,
    output logic                     rf_write_o,
    output logic [SLOT_W+ADDR_W-1:0] rm_addr_o,
    output logic [DATA_W-1:0]        rm_writedata_o,
    input  logic [DATA_W-1:0]        rm_readdata_i,
    output logic                     rm_read_o,
    output logic                     rm_write_o,
    input  logic                     rm_busywait_i
);
    typedef enum logic [2:0] {IDLE, SV_RD, SV_WR, RS_RD, RS_WR, FIN} state_t;
    localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_X0 ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last;
    assign last = idx_q == LAST_IDX;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            slot_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            data_q  <= data_d;
        end
    end
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        slot_d         = slot_q;
        data_d         = data_q;
        done_o         = 1'b0;
        rf_addr_o      = '0;
        rf_writedata_o = '0;
        rf_write_o     = 1'b0;
        rm_addr_o      = '0;
        rm_writedata_o = '0;
        rm_read_o      = 1'b0;
        rm_write_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (save_req_i || restore_req_i) begin
                    slot_d  = slot_i;
                    idx_d   = FIRST_IDX;
                    state_d = save_req_i ? SV_RD : RS_RD;
                end
            end
            SV_RD: begin
                rf_addr_o = idx_q;
                data_d    = rf_readdata_i;
                state_d   = SV_WR;
            end
            SV_WR: begin
                rm_write_o     = 1'b1;
                rm_addr_o      = {slot_q, idx_q};
                rm_writedata_o = data_q;
                if (!rm_busywait_i) begin
                    state_d = last ? FIN : SV_RD;
                    idx_d   = last ? idx_q : idx_q + ADDR_W'(1);
                end
            end
            RS_RD: begin
                rm_read_o = 1'b1;
                rm_addr_o = {slot_q, idx_q};
                if (!rm_busywait_i) begin
                    data_d  = rm_readdata_i;
                    state_d = RS_WR;
                end
            end
            RS_WR: begin
                rf_write_o     = 1'b1;
                rf_addr_o      = idx_q;
                rf_writedata_o = data_q;
                state_d        = last ? FIN : RS_RD;
                idx_d          = last ? idx_q : idx_q + ADDR_W'(1);
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Stall starts combinationally with the request so the pipeline never slips a cycle.
    assign busywait_o = rst_ni && ((state_q != IDLE && state_q != FIN) ||
                                   (state_q == IDLE && (save_req_i || restore_req_i)));
endmodule

// File: tb/tb_reg_ctx_swap_ctrl.sv
// tb_reg_ctx_swap_ctrl: scoreboard bench with RF/RM models; u0 skips x0, u1 transfers all 32 registers.
module tb_reg_ctx_swap_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic save_req = 1'b0, restore_req = 1'b0, sel = 1'b0;
    logic [1:0] slot = 2'd0;
    logic [31:0] rf_rdata, rm_rdata;
    logic rm_busy;
    logic busy0, done0, rf_we0, rm_rd0, rm_we0, busy1, done1, rf_we1, rm_rd1, rm_we1;
    logic [4:0] rf_addr0, rf_addr1;
    logic [6:0] rm_addr0, rm_addr1;
    logic [31:0] rf_wd0, rm_wd0, rf_wd1, rm_wd1;
    logic m_busy, m_done, m_rf_we, m_rm_rd, m_rm_we;
    logic [4:0] m_rf_addr;
    logic [6:0] m_rm_addr;
    logic [31:0] m_rf_wd, m_rm_wd;
    logic [31:0] rf [32];
    logic [31:0] rm [128];
    int wait_n = 0, wcnt = 0, cyc = 0, checks = 0, errors = 0, done_cnt = 0, rd_hold = 0;
    bit mode_save = 1'b0, rf_we_prev = 1'b0;
    logic [38:0] exp_rm [$];
    logic [36:0] exp_rf [$];
    int exp_done [$];

    reg_ctx_swap_ctrl u0 (
        .clk_i(clk), .rst_ni(rst_n), .save_req_i(save_req & ~sel), .restore_req_i(restore_req & ~sel),
        .slot_i(slot), .busywait_o(busy0), .done_o(done0), .rf_addr_o(rf_addr0), .rf_readdata_i(rf_rdata),
        .rf_writedata_o(rf_wd0), .rf_write_o(rf_we0), .rm_addr_o(rm_addr0), .rm_writedata_o(rm_wd0),
        .rm_readdata_i(rm_rdata), .rm_read_o(rm_rd0), .rm_write_o(rm_we0), .rm_busywait_i(rm_busy));
    reg_ctx_swap_ctrl #(.SKIP_X0(1'b0)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .save_req_i(save_req & sel), .restore_req_i(restore_req & sel),
        .slot_i(slot), .busywait_o(busy1), .done_o(done1), .rf_addr_o(rf_addr1), .rf_readdata_i(rf_rdata),
        .rf_writedata_o(rf_wd1), .rf_write_o(rf_we1), .rm_addr_o(rm_addr1), .rm_writedata_o(rm_wd1),
        .rm_readdata_i(rm_rdata), .rm_read_o(rm_rd1), .rm_write_o(rm_we1), .rm_busywait_i(rm_busy));

    assign m_busy    = sel ? busy1 : busy0;
    assign m_done    = sel ? done1 : done0;
    assign m_rf_we   = sel ? rf_we1 : rf_we0;
    assign m_rm_rd   = sel ? rm_rd1 : rm_rd0;
    assign m_rm_we   = sel ? rm_we1 : rm_we0;
    assign m_rf_addr = sel ? rf_addr1 : rf_addr0;
    assign m_rm_addr = sel ? rm_addr1 : rm_addr0;
    assign m_rf_wd   = sel ? rf_wd1 : rf_wd0;
    assign m_rm_wd   = sel ? rm_wd1 : rm_wd0;
    assign rf_rdata  = rf[m_rf_addr];
    assign rm_rdata  = rm[m_rm_addr];
    assign rm_busy   = (m_rm_rd || m_rm_we) && (wcnt < wait_n);

    // RF/RM models: RM stalls wait_n cycles per access, then accepts.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        wcnt <= ((m_rm_rd || m_rm_we) && rm_busy) ? wcnt + 1 : 0;
        if (m_rf_we) rf[m_rf_addr] = m_rf_wd;
        if (m_rm_we && !rm_busy) rm[m_rm_addr] = m_rm_wd;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_out_zero(input string name);
        chk({name, "_ctrl"}, 64'({m_busy, m_done, m_rf_we, m_rm_rd, m_rm_we, m_rf_addr, m_rm_addr}), 64'd0);
        chk({name, "_data"}, {m_rf_wd, m_rm_wd}, 64'd0);
    endtask

    // Monitor: pops expectations as the DUT presents accesses and pulses.
    always @(negedge clk) begin
        chk("rm_strobe_excl", 64'(m_rm_rd & m_rm_we), 64'd0);
        chk("rf_write_in_save", 64'(mode_save & m_rf_we), 64'd0);
        chk("rm_read_in_save", 64'(mode_save & m_rm_rd), 64'd0);
        chk("rf_write_single", 64'(rf_we_prev & m_rf_we), 64'd0);
        if (m_rm_we && !rm_busy) begin
            if (exp_rm.size() == 0) begin
                checks++; errors++;
                $display("FAIL rm_write unexpected: got addr %0h data %0h expected none", m_rm_addr, m_rm_wd);
            end else chk("rm_write", 64'({m_rm_addr, m_rm_wd}), 64'(exp_rm.pop_front()));
        end
        if (m_rf_we) begin
            if (exp_rf.size() == 0) begin
                checks++; errors++;
                $display("FAIL rf_write unexpected: got addr %0h data %0h expected none", m_rf_addr, m_rf_wd);
            end else chk("rf_write", 64'({m_rf_addr, m_rf_wd}), 64'(exp_rf.pop_front()));
        end
        if (m_rm_rd) begin
            rd_hold++;
            if (!rm_busy) begin
                chk("rm_read_hold", 64'(rd_hold), 64'(wait_n + 1));
                rd_hold = 0;
            end
        end
        if (m_done) begin
            done_cnt++;
            if (exp_done.size() == 0) begin
                checks++; errors++;
                $display("FAIL done unexpected: got pulse at cycle %0d expected none", cyc);
            end else chk("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
        end
        rf_we_prev = m_rf_we;
    end

    // Called just after a posedge; runs one transfer and checks the return to idle.
    task automatic xfer(input bit sv, input bit rs, input logic [1:0] s, input int w, input bit hold_fin);
        int first, lim;
        first = sel ? 0 : 1;
        wait_n = w;
        mode_save = sv;
        for (int i = first; i < 32; i++) begin
            if (sv) exp_rm.push_back({s, 5'(i), rf[i]});
            else exp_rf.push_back({5'(i), rm[{s, 5'(i)}]});
        end
        exp_done.push_back(cyc + (2 + w) * (32 - first) + 1);
        save_req = sv;
        restore_req = rs;
        slot = s;
        #1 chk("busy_req_cycle", 64'(m_busy), 64'd1);
        lim = 0;
        while (!m_done && lim < 400) begin
            @(posedge clk); #1;
            lim++;
            if (lim == 5) slot = ~s;
        end
        chk("done_seen", 64'(m_done), 64'd1);
        if (hold_fin) begin
            @(posedge clk); #1;
        end
        save_req = 1'b0;
        restore_req = 1'b0;
        @(posedge clk); #1;
        chk("idle_after", 64'({m_busy, m_done}), 64'd0);
        chk("queues_drained", 64'(exp_rm.size() + exp_rf.size() + exp_done.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] snap [32];
        int lim, nbad, d0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
        for (int i = 0; i < 128; i++) rm[i] = 32'hDEAD0000 | 32'(i);
        save_req = 1'b1;
        #1 chk_out_zero("reset_outputs");
        save_req = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 64'({m_busy, m_done}), 64'd0);

        // T1: zero-wait save to slot 2, slot input changed mid-transfer
        xfer(1'b1, 1'b0, 2'd2, 0, 1'b0);
        chk("t1_x0_untouched", 64'(rm[64]), 64'h0000_0000_DEAD_0040);
        chk("t1_last_reg", 64'(rm[{2'd2, 5'd31}]), 64'h101F);

        // T3: both requests together, save must win
        xfer(1'b1, 1'b1, 2'd0, 1, 1'b0);
        chk("t3_saved", 64'(rm[7]), 64'h1007);

        // T2: restore slot 1 with three RM wait cycles per read
        for (int i = 0; i < 32; i++) rm[{2'd1, 5'(i)}] = ~32'(i);
        xfer(1'b0, 1'b1, 2'd1, 3, 1'b0);
        chk("t2_rf5", 64'(rf[5]), 64'hFFFF_FFFA);
        chk("t2_rf0_kept", 64'(rf[0]), 64'h1000);

        // T4: async reset in SV_WR at idx 10
        mode_save = 1'b1;
        wait_n = 0;
        for (int i = 1; i < 32; i++) exp_rm.push_back({2'd0, 5'(i), rf[i]});
        save_req = 1'b1;
        slot = 2'd0;
        lim = 0;
        while (!(m_rm_we && m_rm_addr == 7'd10) && lim < 200) begin
            @(posedge clk); #1;
            lim++;
        end
        chk("t4_reached_idx10", 64'({m_rm_we, m_rm_addr}), 64'({1'b1, 7'd10}));
        #2 rst_n = 1'b0;
        save_req = 1'b0;
        #1 chk_out_zero("t4_async_reset");
        exp_rm.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t4_idle", 64'({m_busy, m_done}), 64'd0);
        xfer(1'b1, 1'b0, 2'd1, 0, 1'b0);

        // T5: save then restore slot 3, requests held into FIN
        for (int i = 0; i < 32; i++) snap[i] = rf[i];
        d0 = done_cnt;
        xfer(1'b1, 1'b0, 2'd3, 0, 1'b1);
        xfer(1'b0, 1'b1, 2'd3, 2, 1'b1);
        nbad = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== snap[i]) nbad++;
        chk("t5_rf_unchanged", 64'(nbad), 64'd0);
        chk("t5_done_pulses", 64'(done_cnt - d0), 64'd2);

        // T6: instance without x0 skip saves all 32 registers into slot 0
        sel = 1'b1;
        rf[0] = 32'hC0FFEE00;
        xfer(1'b1, 1'b0, 2'd0, 0, 1'b0);
        chk("t6_x0_saved", 64'(rm[0]), 64'hC0FF_EE00);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
